// File: rtl/ro_buffer.sv
// ro_buffer: in-order reorder buffer with dual result-bus capture and a one-cycle mispredict flush.
// Optional macro RO_BUFFER_COMMIT_BYPASS_EN lets the head retire on the same edge its result arrives.
module ro_buffer #(
  parameter int DEPTH = 16,
  parameter int ID_W  = 5,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            alloc_from_issuer,
  input  logic [4:0]      rd_from_issuer,
  input  logic            is_branch_from_issuer,
  input  logic [XLEN-1:0] predicted_pc_from_issuer,
  output logic [ID_W-1:0] next_id_to_issuer,
  output logic            is_ro_buffer_full,
  input  logic [ID_W-1:0] dest_from_rss_bus,
  input  logic [XLEN-1:0] value_from_rss_bus,
  input  logic [XLEN-1:0] next_pc_from_rss_bus,
  input  logic [ID_W-1:0] dest_from_lsb_bus,
  input  logic [XLEN-1:0] value_from_lsb_bus,
  input  logic [ID_W-1:0] query_j_id,
  input  logic [ID_W-1:0] query_k_id,
  output logic            query_j_ready,
  output logic            query_k_ready,
  output logic [XLEN-1:0] query_j_value,
  output logic [XLEN-1:0] query_k_value,
  output logic [ID_W-1:0] commit_dest_to_bus,
  output logic [4:0]      commit_rd_to_reg_file,
  output logic [XLEN-1:0] commit_value_to_reg_file,
  output logic            reset_to_rob_bus,
  output logic [XLEN-1:0] target_pc_to_rob_bus
);
  localparam logic [ID_W-1:0] FIRST_ID = ID_W'(1);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(DEPTH);
  localparam logic [ID_W:0]   CNT_FULL = (ID_W+1)'(DEPTH);
  localparam logic [ID_W:0]   CNT_PRE  = (ID_W+1)'(DEPTH - 1);

  logic [DEPTH:1]  busy, done;
  logic [DEPTH:1]  is_br;
  logic [4:0]      rd_q      [1:DEPTH];
  logic [XLEN-1:0] value_q   [1:DEPTH];
  logic [XLEN-1:0] pred_pc_q [1:DEPTH];
  logic [XLEN-1:0] act_pc_q  [1:DEPTH];
  logic [ID_W-1:0] head, tail;
  logic [ID_W:0]   count;

  logic            lsb_hit, rss_hit, rss_wr, alloc_ok;
  logic            head_done, commit, mispredict;
  logic [XLEN-1:0] head_value, head_pc;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? FIRST_ID : id + FIRST_ID;
  endfunction

  function automatic logic valid_id(input logic [ID_W-1:0] id);
    return (id != '0) && (id <= LAST_ID);
  endfunction

  // reset_to_rob_bus doubles as the flush-cycle flag: upstream inputs are stale while it is high.
  assign lsb_hit  = !reset_to_rob_bus && valid_id(dest_from_lsb_bus) && busy[dest_from_lsb_bus];
  assign rss_hit  = !reset_to_rob_bus && valid_id(dest_from_rss_bus) && busy[dest_from_rss_bus];
  assign rss_wr   = rss_hit && !(lsb_hit && (dest_from_lsb_bus == dest_from_rss_bus));
  assign alloc_ok = !reset_to_rob_bus && alloc_from_issuer && (count < CNT_FULL);

`ifdef RO_BUFFER_COMMIT_BYPASS_EN
  always_comb begin
    head_done  = busy[head] && done[head];
    head_value = value_q[head];
    head_pc    = act_pc_q[head];
    if (lsb_hit && (dest_from_lsb_bus == head)) begin
      head_done  = 1'b1;
      head_value = value_from_lsb_bus;
    end else if (rss_wr && (dest_from_rss_bus == head)) begin
      head_done  = 1'b1;
      head_value = value_from_rss_bus;
      head_pc    = next_pc_from_rss_bus;
    end
  end
`else
  assign head_done  = busy[head] && done[head];
  assign head_value = value_q[head];
  assign head_pc    = act_pc_q[head];
`endif

  assign commit     = head_done;
  assign mispredict = commit && is_br[head] && (head_pc != pred_pc_q[head]);

  assign next_id_to_issuer = tail;
  assign is_ro_buffer_full = (count >= CNT_PRE);

  function automatic logic [XLEN:0] lookup(input logic [ID_W-1:0] id);
    if (reset_to_rob_bus) return '0;
    if (id == '0) return {1'b1, {XLEN{1'b0}}};
    if ((dest_from_lsb_bus != '0) && (id == dest_from_lsb_bus)) return {1'b1, value_from_lsb_bus};
    if ((dest_from_rss_bus != '0) && (id == dest_from_rss_bus)) return {1'b1, value_from_rss_bus};
    if (valid_id(id) && busy[id] && done[id]) return {1'b1, value_q[id]};
    return '0;
  endfunction

  always_comb begin
    {query_j_ready, query_j_value} = lookup(query_j_id);
    {query_k_ready, query_k_value} = lookup(query_k_id);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head                     <= FIRST_ID;
      tail                     <= FIRST_ID;
      count                    <= '0;
      busy                     <= '0;
      done                     <= '0;
      commit_dest_to_bus       <= '0;
      commit_rd_to_reg_file    <= '0;
      commit_value_to_reg_file <= '0;
      reset_to_rob_bus         <= 1'b0;
      target_pc_to_rob_bus     <= '0;
    end else if (rdy) begin
      reset_to_rob_bus         <= mispredict;
      target_pc_to_rob_bus     <= mispredict ? head_pc : '0;
      commit_dest_to_bus       <= commit ? head : '0;
      commit_rd_to_reg_file    <= commit ? rd_q[head] : '0;
      commit_value_to_reg_file <= commit ? head_value : '0;
      if (mispredict) begin
        busy  <= '0;
        done  <= '0;
        head  <= FIRST_ID;
        tail  <= FIRST_ID;
        count <= '0;
      end else begin
        if (lsb_hit) done[dest_from_lsb_bus] <= 1'b1;
        if (rss_wr)  done[dest_from_rss_bus] <= 1'b1;
        if (alloc_ok) begin
          busy[tail] <= 1'b1;
          done[tail] <= 1'b0;
          tail       <= wrap_inc(tail);
        end
        if (commit) begin
          busy[head] <= 1'b0;
          done[head] <= 1'b0;
          head       <= wrap_inc(head);
        end
        count <= count + (ID_W+1)'(alloc_ok) - (ID_W+1)'(commit);
      end
    end
  end

  // Payload needs no reset: it is only observed once busy marks the entry live.
  // actual_pc starts equal to the prediction so an entry completed only via LSB never mispredicts.
  always_ff @(posedge clk) begin
    if (rdy && !mispredict) begin
      if (lsb_hit) value_q[dest_from_lsb_bus] <= value_from_lsb_bus;
      if (rss_wr) begin
        value_q[dest_from_rss_bus]  <= value_from_rss_bus;
        act_pc_q[dest_from_rss_bus] <= next_pc_from_rss_bus;
      end
      if (alloc_ok) begin
        rd_q[tail]      <= rd_from_issuer;
        is_br[tail]     <= is_branch_from_issuer;
        pred_pc_q[tail] <= predicted_pc_from_issuer;
        act_pc_q[tail]  <= predicted_pc_from_issuer;
      end
    end
  end

endmodule
